// File: rtl/wb_pkg.sv
// Shared types and widths for the Wishbone classic initiator.
// Holds the FSM state encoding and the latched command bundle.
package wb_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic                we;
        logic [WB_SEL_W-1:0] sel;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
    } wb_cmd_t;

endpackage

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator with registered bus outputs.
// A command is latched in IDLE, run on the bus, then held as a response.
module wb_initiator
    import wb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [WB_SEL_W-1:0] cmd_sel_i,
    input  logic [WB_ADR_W-1:0] cmd_adr_i,
    input  logic [WB_DAT_W-1:0] cmd_dat_i,

    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [WB_DAT_W-1:0] rsp_dat_o,
    output logic                rsp_err_o,

    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [WB_SEL_W-1:0] wbm_sel_o,
    output logic [WB_ADR_W-1:0] wbm_adr_o,
    output logic [WB_DAT_W-1:0] wbm_dat_o,
    input  logic [WB_DAT_W-1:0] wbm_dat_i,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,

    output logic                busy_o
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int unsigned CNT_W =
        TO_EN ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                 $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
    // Counter value seen in the last BUS cycle before a timeout fires.
    localparam logic [CNT_W-1:0] CNT_LAST =
        TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    wb_state_e           state_q, state_d;
    wb_cmd_t             cmd_q, cmd_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                cyc_q, cyc_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [WB_DAT_W-1:0] rsp_dat_q, rsp_dat_d;
    logic                rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                timeout;

    assign timeout = TO_EN && (cnt_q == CNT_LAST);

    // Next-state and next-output logic; err beats ack, ack beats timeout.
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_ready_d = cmd_ready_q;
        cyc_d       = cyc_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid_i && cmd_ready_q) begin
                    cmd_d.we    = cmd_we_i;
                    cmd_d.sel   = cmd_sel_i;
                    cmd_d.adr   = cmd_adr_i;
                    cmd_d.dat   = cmd_dat_i;
                    cmd_ready_d = 1'b0;
                    cyc_d       = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUS;
                end
            end
            BUS: begin
                if (wbm_err_i || (!wbm_ack_i && timeout)) begin
                    rsp_dat_d   = '0;
                    rsp_err_d   = 1'b1;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (wbm_ack_i) begin
                    rsp_dat_d   = cmd_q.we ? '0 : wbm_dat_i;
                    rsp_err_d   = 1'b0;
                    cyc_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (TO_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cyc_d       = 1'b0;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_ready_q <= cmd_ready_d;
            cyc_q       <= cyc_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_ready_o = cmd_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;
    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = cmd_q.we;
    assign wbm_sel_o   = cmd_q.sel;
    assign wbm_adr_o   = cmd_q.adr;
    assign wbm_dat_o   = cmd_q.dat;
    assign busy_o      = (state_q != IDLE);

endmodule
